// File: rtl/klp32_ctrl_pkg.sv
// Shared encodings for the KLP32 multi-cycle controller, immediate generator and datapath muxes.
// Holds the opcodes, FSM states, mux selects and the control-word bundle.
package klp32_ctrl_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_LUI      = 4'd11,
      S_TRAP     = 4'd12
   } state_t;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_U = 3'b011,
      IMM_J = 3'b100
   } imm_sel_t;

   typedef enum logic [1:0] {
      SRC_A_PC     = 2'b00,
      SRC_A_OLD_PC = 2'b01,
      SRC_A_RS1    = 2'b10
   } src_a_t;

   typedef enum logic [1:0] {
      SRC_B_RS2  = 2'b00,
      SRC_B_IMM  = 2'b01,
      SRC_B_FOUR = 2'b10
   } src_b_t;

   typedef enum logic [1:0] {
      ALU_ADD    = 2'b00,
      ALU_SUB    = 2'b01,
      ALU_FUNCT  = 2'b10,
      ALU_PASS_B = 2'b11
   } alu_op_t;

   typedef enum logic [1:0] {
      RES_ALU_OUT    = 2'b00,
      RES_READ_DATA  = 2'b01,
      RES_ALU_RESULT = 2'b10
   } result_src_t;

   typedef struct packed {
      logic        mem_req;
      logic        mem_we;
      logic        adr_src;
      logic        ir_write;
      logic        pc_write;
      logic        reg_write;
      imm_sel_t    imm_sel;
      src_a_t      alu_src_a;
      src_b_t      alu_src_b;
      alu_op_t     alu_op;
      result_src_t result_src;
      logic        illegal_instr;
   } ctrl_t;

   // Dispatch out of DECODE: unsupported opcodes fall into the trap state.
   function automatic state_t decode_next(input logic [6:0] opcode);
      state_t nxt;
      case (opcode)
         OP_LW, OP_SW: nxt = S_MEMADR;
         OP_R:         nxt = S_EXECR;
         OP_I:         nxt = S_EXECI;
         OP_BR:        nxt = S_BRANCH;
         OP_JAL:       nxt = S_JAL;
         OP_LUI:       nxt = S_LUI;
         default:      nxt = S_TRAP;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational control-word decode for the multi-cycle controller.
// Mostly Moore; ir_write/pc_write in FETCH and pc_write in BRANCH follow their inputs.
module mc_ctrl_outdec
   import klp32_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       mem_ready,
   output ctrl_t      ctrl
);

   // Only bit 0 separates beq from bne; the other funct3 bits are ignored.
   logic unused_funct3;
   assign unused_funct3 = ^funct3[2:1];

   always_comb begin
      // NOTE: full default first, so no path through the case can infer a latch.
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_req    = 1'b1;
            ctrl.alu_src_b  = SRC_B_FOUR;
            ctrl.result_src = RES_ALU_RESULT;
            ctrl.ir_write   = mem_ready;
            ctrl.pc_write   = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_a = SRC_A_OLD_PC;
            ctrl.alu_src_b = SRC_B_IMM;
            if (opcode == OP_JAL) ctrl.imm_sel = IMM_J;
            else                  ctrl.imm_sel = IMM_B;
         end
         S_MEMADR: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_IMM;
            if (opcode == OP_SW) ctrl.imm_sel = IMM_S;
            else                 ctrl.imm_sel = IMM_I;
         end
         S_MEMREAD: begin
            ctrl.mem_req = 1'b1;
            ctrl.adr_src = 1'b1;
         end
         S_MEMWB: begin
            ctrl.result_src = RES_READ_DATA;
            ctrl.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl.mem_req = 1'b1;
            ctrl.mem_we  = 1'b1;
            ctrl.adr_src = 1'b1;
         end
         S_EXECR: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_EXECI: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_LUI: begin
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.imm_sel   = IMM_U;
            ctrl.alu_op    = ALU_PASS_B;
         end
         S_ALUWB: begin
            ctrl.reg_write = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_op    = ALU_SUB;
            ctrl.pc_write  = zero ^ funct3[0];
         end
         S_JAL: begin
            ctrl.alu_src_a = SRC_A_OLD_PC;
            ctrl.alu_src_b = SRC_B_FOUR;
            ctrl.pc_write  = 1'b1;
         end
         S_TRAP: begin
            ctrl.illegal_instr = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// KLP32 multi-cycle main controller: state register, next-state logic and output gating.
// One instruction at a time; memory states hold until mem_ready.
module mc_ctrl_fsm
   import klp32_ctrl_pkg::*;
#(
   parameter int IMM_SEL_W = 3,
   parameter int STATE_W   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6:0]           opcode,
   input  logic [2:0]           funct3,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 adr_src,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 reg_write,
   output logic [IMM_SEL_W-1:0] imm_sel,
   output logic [1:0]           alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           alu_op,
   output logic [1:0]           result_src,
   output logic                 retire,
   output logic                 illegal_instr,
   output logic [STATE_W-1:0]   state_o
);

   state_t state;
   state_t state_nxt;
   ctrl_t  ctrl;

   always_comb begin
      state_nxt = S_FETCH;
      case (state)
         S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
                     else           state_nxt = S_FETCH;
         S_DECODE:   state_nxt = decode_next(opcode);
         S_MEMADR:   if (opcode == OP_SW) state_nxt = S_MEMWRITE;
                     else                 state_nxt = S_MEMREAD;
         S_MEMREAD:  if (mem_ready) state_nxt = S_MEMWB;
                     else           state_nxt = S_MEMREAD;
         S_MEMWRITE: if (mem_ready) state_nxt = S_FETCH;
                     else           state_nxt = S_MEMWRITE;
         S_EXECR,
         S_EXECI,
         S_LUI,
         S_JAL:      state_nxt = S_ALUWB;
         S_TRAP:     state_nxt = S_TRAP;
         default:    state_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignment only.
      if (!rst_n) state <= S_FETCH;
      else        state <= state_nxt;
   end

   mc_ctrl_outdec u_outdec (
      .state     (state),
      .opcode    (opcode),
      .funct3    (funct3),
      .zero      (zero),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );

   // NOTE: FETCH requests memory, so enables are gated by rst_n to stay quiet during reset.
   assign mem_req       = ctrl.mem_req       & rst_n;
   assign mem_we        = ctrl.mem_we        & rst_n;
   assign ir_write      = ctrl.ir_write      & rst_n;
   assign pc_write      = ctrl.pc_write      & rst_n;
   assign reg_write     = ctrl.reg_write     & rst_n;
   assign illegal_instr = ctrl.illegal_instr & rst_n;
   assign retire        = rst_n & (state != S_FETCH) & (state_nxt == S_FETCH);

   assign adr_src    = ctrl.adr_src;
   assign imm_sel    = IMM_SEL_W'(ctrl.imm_sel);
   assign alu_src_a  = ctrl.alu_src_a;
   assign alu_src_b  = ctrl.alu_src_b;
   assign alu_op     = ctrl.alu_op;
   assign result_src = ctrl.result_src;
   assign state_o    = STATE_W'(state);

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle main controller for the KLP32 RV32I core. It sequences the shared datapath (PC, instruction register, ALU, immediate generator, register file, unified memory port) one instruction at a time. It drives the immediate-generator select, the ALU operand muxes and the write enables, and stalls on a ready-based memory handshake. Supported instructions: lw, sw, R-type, I-type ALU, beq/bne, jal, lui. Any other opcode traps.

Parameters:
IMM_SEL_W, 3, width of imm_sel (must match the immediate generator's select width)
STATE_W, 4, width of the state register and the state_o debug port

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
opcode  in  7  instr[6:0] from the instruction register
funct3  in  3  instr[14:12]
zero  in  1  ALU zero flag, combinational from the current ALU result
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write strobe; valid only while mem_req=1
adr_src  out  1  memory address select: 0=PC, 1=ALUOut
ir_write  out  1  load instruction register and oldPC
pc_write  out  1  load PC from the result bus
reg_write  out  1  register-file write enable
imm_sel  out  IMM_SEL_W  000=I, 001=S, 010=B, 011=U, 100=J
alu_src_a  out  2  00=PC, 01=oldPC, 10=rs1
alu_src_b  out  2  00=rs2, 01=imm, 10=const 4
alu_op  out  2  00=add, 01=sub, 10=funct-decoded, 11=pass B
result_src  out  2  00=ALUOut reg, 01=read data, 10=ALU result
retire  out  1  one-cycle pulse when an instruction completes
illegal_instr  out  1  sticky trap flag
state_o  out  STATE_W  current state (debug)

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, LUI=11, TRAP=12. Encodings 13-15 go to FETCH next cycle.
- Reset: state<=FETCH asynchronously. While rst_n=0, mem_req, mem_we, ir_write, pc_write, reg_write, retire and illegal_instr are forced to 0. Other outputs take their FETCH values.
- Unless listed for a state, every enable=0, imm_sel=000, and mux selects=00.
- FETCH: mem_req=1, adr_src=0, src_a=00, src_b=10, alu_op=00, result_src=10.
  - ir_write=pc_write=mem_ready (Mealy).
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: src_a=01, src_b=01, alu_op=00. imm_sel=100 if opcode=jal, else 010.
  - Next state by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 0110111 -> LUI; any other -> TRAP.
- MEMADR: src_a=10, src_b=01, alu_op=00. imm_sel=000 for lw, 001 for sw. Next: MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: mem_req=1, adr_src=1. Waits for mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: mem_req=1, mem_we=1, adr_src=1. Waits for mem_ready, then FETCH.
- EXECR: src_a=10, src_b=00, alu_op=10, then ALUWB.
- EXECI: src_a=10, src_b=01, imm_sel=000, alu_op=10, then ALUWB.
- LUI: src_b=01, imm_sel=011, alu_op=11, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BRANCH: src_a=10, src_b=00, alu_op=01, result_src=00.
  - pc_write = zero XOR funct3[0] (beq/bne). Other funct3 values are treated as beq/bne by bit 0.
  - Next: FETCH.
- JAL: src_a=01, src_b=10, alu_op=00, result_src=00, pc_write=1. Next: ALUWB, which writes PC+4 into rd.
- TRAP: all enables 0, illegal_instr=1. Stays in TRAP until reset.
- retire=1 in the cycle the next state is FETCH and the current state is not FETCH.
- Latency with mem_ready held at 1 (cycles per instruction): lw 5, sw 4, R/I/lui 4, branch 3, jal 4. Each mem_ready=0 cycle adds one cycle.
- A memory request is never abandoned except by reset. Outputs stay stable while waiting for mem_ready.

Decomposition:
- Package klp32_ctrl_pkg holds:
  - opcode constants
  - state encodings
  - imm_sel encodings (shared with the immediate generator)
  - alu_src_a/alu_src_b/result_src/alu_op encodings
- One sub-module, mc_ctrl_outdec: purely combinational decode of (state, opcode, funct3, zero, mem_ready) to all control outputs.
- mc_ctrl_fsm keeps the state register and next-state logic.

Test Plan:
1. Assert rst_n=0 while in MEMREAD with mem_req=1 -> state_o=0 immediately, all enables 0 while low; mem_req=1 in the first cycle after release.
2. lw (opcode 0000011), mem_ready low for 3 cycles in FETCH -> FETCH held 4 cycles; imm_sel=000 in MEMADR; reg_write=1 with result_src=01 in MEMWB; retire pulses once; 8 cycles total.
3. sw (0100011) -> imm_sel=001 in MEMADR; mem_we=1 only in MEMWRITE with adr_src=1; reg_write never asserted.
4. beq (funct3=000) with zero=1 -> pc_write=1 in BRANCH. bne (001) with zero=1 -> pc_write=0. bne with zero=0 -> pc_write=1.
5. jal (1101111) -> imm_sel=100 in DECODE; pc_write=1 in JAL; reg_write=1 in ALUWB; 4 cycles.
6. Opcode 1111111 -> TRAP; illegal_instr=1; mem_req stays 0 for 20 cycles; a reset pulse returns to FETCH with illegal_instr=0.
